// File: rtl/mem_pkg.sv
// mem_pkg: shared types, default sizes and the write-priority helper for
// the multiport_mem storage block.
//   mem_state_e    : INIT (clear sweep running) / RUN (ports live)
//   DEF_*          : default parameter values used by multiport_mem
//   MAX_PORTS      : widest port count the priority helper supports
//   hi_prio_select : one-hot grant of the highest-index requester
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int MAX_PORTS  = 32;

  // Highest-index requester wins: later loop iterations overwrite earlier
  // grants, so the surviving bit is the topmost set bit of req.
  function automatic logic [MAX_PORTS-1:0] hi_prio_select(
    input logic [MAX_PORTS-1:0] req
  );
    logic [MAX_PORTS-1:0] gnt;
    gnt = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// mem_init_ctrl: INIT/RUN state machine plus the clear-sweep counter.
// After reset it steps o_clr_addr through 0..DEPTH-1, one entry per cycle,
// with o_clr_en high; the edge that clears entry DEPTH-1 moves it to RUN,
// where o_init_done stays high until the next reset.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   o_clr_addr  : entry being zeroed this cycle
//   o_clr_en    : clear strobe (high for the whole of INIT)
//   o_init_done : sweep complete, ports live
module mem_init_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_en,
  output logic              o_init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_en    = 1'b0;
    o_init_done = 1'b0;
    unique case (r_state)
      INIT: begin
        o_clr_en = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        o_init_done = 1'b1;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/multiport_mem.sv
// multiport_mem: NUM_WR-write / NUM_RD-read synchronous memory with a
// one-cycle registered read path and a post-reset clear sweep.
//   clk, rst_n  : clock (rising edge), synchronous active-low reset
//   wr_en/wr_addr/wr_data : per-port write request (packed arrays)
//   rd_en/rd_addr         : per-port read request (packed arrays)
//   rd_data/rd_valid      : registered read result, valid for one cycle
//   init_done   : clear sweep finished, ports live
//   wr_conflict : registered one-cycle pulse, >=2 enabled in-range writes
//                 to the same address on the previous edge
// Writes to the same address resolve highest-index-port-wins; addresses
// >= DEPTH are dropped on write and read back as 0.
// Build option: define MEM_BYPASS_EN for write-first reads (a read on the
// same edge as a write to its address returns the new data); otherwise
// reads are read-first and return the pre-edge contents.
// NUM_WR must not exceed mem_pkg::MAX_PORTS.
module multiport_mem
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic                           init_done,
  output logic                           wr_conflict
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [NUM_RD-1:0][DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]             r_rd_valid;
  logic                          r_wr_conflict;

  logic [ADDR_W-1:0]             w_clr_addr;
  logic                          w_clr_en;
  logic                          w_run;
  logic [NUM_WR-1:0]             w_wr_ok;
  logic [NUM_WR-1:0]             w_wr_commit;
  logic                          w_conflict;
  logic [MAX_PORTS-1:0]          w_req;
  logic [MAX_PORTS-1:0]          w_gnt;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_word;

  mem_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_clr_addr  (w_clr_addr),
    .o_clr_en    (w_clr_en),
    .o_init_done (w_run)
  );

  // A write is a candidate only while live, outside reset and in range.
  always_comb begin
    w_wr_ok = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_wr_ok[i] = rst_n && w_run && wr_en[i] && ({1'b0, wr_addr[i]} < DEPTH_L);
    end
  end

  // For each port, gather every candidate aimed at the same address and
  // keep only the highest-index one. More than one requester on any
  // address means a conflict.
  always_comb begin
    w_wr_commit = '0;
    w_conflict  = 1'b0;
    w_req       = '0;
    w_gnt       = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_req = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        w_req[j] = w_wr_ok[j] && (wr_addr[j] == wr_addr[i]);
      end
      w_gnt          = hi_prio_select(w_req);
      w_wr_commit[i] = w_gnt[i];
      if (w_req != w_gnt) begin
        w_conflict = 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset term; the clear sweep zeroes it
  // after every reset, which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (w_wr_commit[i]) begin
        r_mem[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  // Read word selection. Committed writes target distinct addresses, so at
  // most one can match a given read address when forwarding.
  always_comb begin
    w_rd_word = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_word[p] = r_mem[rd_addr[p]];
`ifdef MEM_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (w_wr_commit[i] && (wr_addr[i] == rd_addr[p])) begin
          w_rd_word[p] = wr_data[i];
        end
      end
`endif
      if ({1'b0, rd_addr[p]} >= DEPTH_L) begin
        w_rd_word[p] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data     <= '0;
      r_rd_valid    <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= w_conflict;
      for (int p = 0; p < NUM_RD; p++) begin
        if (w_run && rd_en[p]) begin
          r_rd_data[p]  <= w_rd_word[p];
          r_rd_valid[p] <= 1'b1;
        end else begin
          r_rd_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign init_done   = w_run;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: doc/multiport_mem.md
# multiport_mem

Parametrised multi-port synchronous memory: NUM_WR write ports and NUM_RD read ports on packed per-port address/data arrays, with a one-cycle registered read path. After reset an internal sweep clears every entry, and the block flags it is ready with init_done. It is the next-generation storage block for the data-memory and register-file slots of the core, with configurable width, depth and port count, deterministic write-conflict resolution and optional write-to-read forwarding.

## Interface
- DATA_W, 32, word width in bits
- ADDR_W, 6, address width
- DEPTH, 1<<ADDR_W, number of entries; DEPTH ≤ 2**ADDR_W
- NUM_RD, 2, read port count (≥1)
- NUM_WR, 2, write port count (≥1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  [NUM_WR-1:0]  per-port write enable
- wr_addr  in  [NUM_WR-1:0][ADDR_W-1:0]  write addresses
- wr_data  in  [NUM_WR-1:0][DATA_W-1:0]  write data
- rd_en  in  [NUM_RD-1:0]  per-port read enable
- rd_addr  in  [NUM_RD-1:0][ADDR_W-1:0]  read addresses
- rd_data  out  [NUM_RD-1:0][DATA_W-1:0]  registered read data
- rd_valid  out  [NUM_RD-1:0]  rd_data updated this cycle
- init_done  out  1  clear sweep complete, ports live
- wr_conflict  out  1  pulse: ≥2 enabled write ports hit the same address

## Operation
- FSM states: INIT, RUN.
- rst_n low at an edge: next state INIT, sweep counter 0. rd_data, rd_valid, init_done and wr_conflict are all 0.
- Reset mid-operation aborts everything and restarts the sweep from entry 0. Contents are not preserved.
- INIT: one entry is zeroed per cycle, counter 0..DEPTH-1.
  - After entry DEPTH-1 is written, the FSM moves to RUN.
  - wr_en and rd_en are ignored. rd_valid stays 0.
- RUN: init_done = 1. All write ports and read ports operate every cycle, independently.
- Write conflict: if ≥2 enabled ports share an address, the highest-index port wins. Losing writes are dropped. wr_conflict is registered and is 1 for exactly one cycle.
- Different addresses on different write ports all commit in the same edge.
- Out of range (addr ≥ DEPTH):
  - A write is dropped and raises no conflict.
  - A read returns 0 with rd_valid = 1.
- rd_en low: rd_data holds its previous value and rd_valid = 0.
- Multiple read ports may hit the same address. Each port returns the same word.

## Timing
- Write sampled at edge k is stored at edge k. It is visible to any read sampled at edge k+1 or later.
- Read latency is 1: rd_addr sampled at edge k gives rd_data/rd_valid driven from edge k until edge k+1.
- Same-edge read and write to the same address follows the MEM_BYPASS_EN behaviour below.
- init_done rises at the edge ending the sweep, DEPTH cycles after the first edge with rst_n high.
- wr_conflict is asserted from the edge after the conflicting edge.

## Configuration
- MEM_BYPASS_EN defined: write-first.
  - A read sampled in the same edge as a write to its address returns the new data.
  - If several ports write that address, the read returns the highest-index port's data.
- MEM_BYPASS_EN undefined: read-first. The read returns the contents before that edge.
- All other behaviour is identical in both builds.

## Structure
- Package mem_pkg holds:
  - the state typedef mem_state_e {INIT, RUN};
  - default width/depth constants;
  - the conflict-resolution function (highest-index-wins priority select).
- One natural sub-module, mem_init_ctrl: the INIT/RUN FSM plus sweep counter. It outputs the clear address, clear strobe and init_done.
- Storage, write arbitration and the read registers stay in multiport_mem.

## Test plan
- Release reset → init_done = 0 for 64 cycles (DEPTH=64), then 1. Read addr 5 on port 0 → rd_data 0x00000000, rd_valid 1.
- Port 0 writes 0x11110011 to addr 0. Port 1 reads addr 0 next cycle → 0x11110011 one cycle later. Port 0 also reads addr 0 → same word.
- Same edge: write 0x11111100 to addr 0 and read addr 0 → 0x11111100 with MEM_BYPASS_EN, 0x11110011 without. A follow-up read → 0x11111100 in both builds.
- Port 0 writes 0xAAAA0000 and port 1 writes 0x5555FFFF to addr 3 in the same edge → wr_conflict 1 for one cycle. A read of addr 3 → 0x5555FFFF.
- Write 0xDEADBEEF to addr 7, then pulse rst_n low for 1 cycle → init_done 0 for 64 cycles, rd_en ignored meanwhile. After RUN, read addr 7 → 0.
- DEPTH=48: write 0x12345678 to addr 50 → no conflict, no effect. Read addr 50 → 0. Read addr 47 → 0.
